input_loader: RTL and testbench
===============================

INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 255: idle cycles tolerated between bytes in LOAD before timeout (used only when INPUT_LOADER_TIMEOUT_EN is defined).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port Clk  in  1  rising-edge clock.
REQ-004 Port Rst  in  1  asynchronous active-low reset.
REQ-005 Port DIn  in  8  input byte.
REQ-006 Port DValid  in  1  DIn valid.
REQ-007 Port DReady  out  1  loader can accept a byte.
REQ-008 Port Sel  in  1  block type: 0 = plaintext (to encrypt), 1 = ciphertext (to decrypt).
REQ-009 Port Clear  in  1  synchronous abort of the current block.
REQ-010 Port PT  out  128  assembled block when Mode=0, else all zeros.
REQ-011 Port CT  out  128  assembled block when Mode=1, else all zeros.
REQ-012 Port Mode  out  1  Sel latched with the first byte of the block.
REQ-013 Port Ry  out  1  complete block available on PT/CT.
REQ-014 Port Ack  in  1  downstream has consumed the block.
REQ-015 Port Err  out  1  one-cycle timeout pulse (tied 0 without INPUT_LOADER_TIMEOUT_EN).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and FULL.
REQ-017 A byte SHALL be accepted only on a Clk edge where DValid=1 and DReady=1.
REQ-018 DReady SHALL be 1 in IDLE and LOAD, and 0 in FULL.
REQ-019 IDLE: an accepted byte SHALL latch Sel into Mode, store the byte at bits [127:120], set the 4-bit byte counter to 1, and go to LOAD.
REQ-020 LOAD: accepted byte n (0-based) SHALL be stored at bits [127-8n:120-8n], MSB-first; bytes not yet written SHALL read 0.
REQ-021 Sel SHALL be ignored after the first byte of a block.
REQ-022 On acceptance of byte 15, the counter SHALL wrap to 0 and the FSM SHALL enter FULL on that same edge; Ry SHALL be 1 on the following cycle (latency 1 clock from last byte).
REQ-023 FULL: Ry=1, and PT/CT SHALL hold stable until Ack=1 is sampled.
REQ-024 On Ack=1 in FULL, the FSM SHALL go to IDLE, and Ry, the data register and Mode SHALL clear to 0.
REQ-025 Ack outside FULL SHALL be ignored.
REQ-026 Clear=1 in any state SHALL go to IDLE and zero the counter, data, Mode and Ry; a byte offered in the same cycle SHALL be discarded.
REQ-027 Clear and Ack together in FULL SHALL behave as Clear.
REQ-028 PT SHALL equal the data register AND ~Mode, and CT SHALL equal the data register AND Mode (bitwise, Mode replicated).

Reset
REQ-029 Rst=0 SHALL immediately force state IDLE, counter 0, data 0, Mode 0, Ry 0, Err 0, DReady 1 and the timeout counter 0, regardless of Clk.
REQ-030 Reset asserted mid-LOAD or in FULL SHALL discard the partial or complete block.
REQ-031 After Rst deasserts, the first Clk edge with DValid=1 SHALL be accepted as byte 0.

Configuration
REQ-032 With INPUT_LOADER_TIMEOUT_EN defined, an 8-bit idle counter SHALL count LOAD cycles with no accepted byte and reset to 0 on each accepted byte.
REQ-033 With INPUT_LOADER_TIMEOUT_EN defined, when the idle counter reaches TO_CYCLES the block SHALL abort as Clear does (REQ-026) and Err SHALL pulse for exactly one cycle.
REQ-034 Without INPUT_LOADER_TIMEOUT_EN, no idle counter SHALL be built, Err SHALL be constant 0, and LOAD SHALL wait indefinitely.

Verification
REQ-035 Sel=0, bytes 0x00..0x0F back-to-back -> Ry=1 one cycle after the last byte; PT=0x000102030405060708090A0B0C0D0E0F; CT=0; Mode=0.
REQ-036 Sel=1 on byte 0 then Sel=0 for the rest, bytes 0xFF each -> CT=all ones, PT=0, Mode=1.
REQ-037 In FULL, hold DValid=1 with DIn=0xAA for 5 cycles, then Ack=1 -> DReady=0 and data unchanged during the 5 cycles; Ry=0 and DReady=1 on the cycle after Ack.
REQ-038 Rst=0 pulse (no clock edge) after 7 bytes -> all outputs 0 at once; a new 16-byte block then loads correctly from byte 0.
REQ-039 Clear=1 together with DValid=1 on byte 9 -> byte discarded; next byte lands at [127:120].
REQ-040 With INPUT_LOADER_TIMEOUT_EN and TO_CYCLES=4, stall 4 cycles after byte 3 -> Err pulses for 1 cycle, state IDLE, PT=0; without the macro, the same stall leaves the block pending and Err=0.

Source files
------------

// File: rtl/input_loader.sv
// input_loader: assembles sixteen bytes, MSB-first, into a 128-bit block and
// presents it as plaintext (PT) or ciphertext (CT) according to the Sel value
// captured with the block's first byte. The block is held until Ack.
// Optional feature macro: INPUT_LOADER_TIMEOUT_EN enables an idle-cycle
// watchdog in LOAD that aborts the partial block and pulses Err.
module input_loader #(
  parameter int TO_CYCLES = 255
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   DIn,
  input  logic         DValid,
  output logic         DReady,
  input  logic         Sel,
  input  logic         Clear,
  output logic [127:0] PT,
  output logic [127:0] CT,
  output logic         Mode,
  output logic         Ry,
  input  logic         Ack,
  output logic         Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [127:0]   data;
  logic           mode;
  logic           ry;
  logic           ready;
  logic           accept;

  // The idle counter is 8 bits wide, so the timeout must fit in it.
  if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to_cycles
    $error("input_loader: TO_CYCLES must be in 1..255");
  end

`ifdef INPUT_LOADER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] idle_cnt;
  logic       err;
  assign Err = err;
`else
  assign Err = 1'b0;
`endif

  // A byte moves only when both sides agree on the same edge.
  assign accept = DValid & ready;

  // Control FSM, byte counter and data register; all outputs are registered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      data  <= 128'd0;
      mode  <= 1'b0;
      ry    <= 1'b0;
      ready <= 1'b1;
`ifdef INPUT_LOADER_TIMEOUT_EN
      idle_cnt <= 8'd0;
      err      <= 1'b0;
`endif
    end else begin
`ifdef INPUT_LOADER_TIMEOUT_EN
      err <= 1'b0;
`endif
      if (Clear) begin
        // Abort wins over everything, including Ack and an offered byte.
        state <= IDLE;
        cnt   <= 4'd0;
        data  <= 128'd0;
        mode  <= 1'b0;
        ry    <= 1'b0;
        ready <= 1'b1;
`ifdef INPUT_LOADER_TIMEOUT_EN
        idle_cnt <= 8'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              mode  <= Sel;
              data  <= {DIn, 120'd0};
              cnt   <= 4'd1;
              state <= LOAD;
`ifdef INPUT_LOADER_TIMEOUT_EN
              idle_cnt <= 8'd0;
`endif
            end
          end
          LOAD: begin
            if (accept) begin
              // Byte n sits at bit offset 8*(15-n); 15-n is ~n for 4 bits.
              data[{~cnt, 3'b000} +: 8] <= DIn;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                state <= FULL;
                ry    <= 1'b1;
                ready <= 1'b0;
              end
`ifdef INPUT_LOADER_TIMEOUT_EN
              idle_cnt <= 8'd0;
            end else if (idle_cnt == TO_LAST) begin
              state    <= IDLE;
              cnt      <= 4'd0;
              data     <= 128'd0;
              mode     <= 1'b0;
              ry       <= 1'b0;
              ready    <= 1'b1;
              idle_cnt <= 8'd0;
              err      <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
`endif
            end
          end
          FULL: begin
            if (Ack) begin
              state <= IDLE;
              data  <= 128'd0;
              mode  <= 1'b0;
              ry    <= 1'b0;
              ready <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
            data  <= 128'd0;
            mode  <= 1'b0;
            ry    <= 1'b0;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign DReady = ready;
  assign Mode   = mode;
  assign Ry     = ry;
  assign PT     = data & {128{~mode}};
  assign CT     = data & {128{mode}};

endmodule

// File: tb/tb_input_loader.sv
// Testbench for input_loader: directed byte streams, with completed blocks
// checked by a scoreboard monitor that pops an expectation on each Ry rise.
module tb_input_loader;

  logic         Clk;
  logic         Rst;
  logic [7:0]   DIn;
  logic         DValid;
  logic         DReady;
  logic         Sel;
  logic         Clear;
  logic [127:0] PT;
  logic [127:0] CT;
  logic         Mode;
  logic         Ry;
  logic         Ack;
  logic         Err;

  input_loader #(.TO_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .DIn(DIn), .DValid(DValid), .DReady(DReady),
    .Sel(Sel), .Clear(Clear), .PT(PT), .CT(CT), .Mode(Mode), .Ry(Ry),
    .Ack(Ack), .Err(Err)
  );

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
    logic         mode;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_ry  = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_block(input logic [7:0] base);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(base + 8'(i))};
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic s);
    DValid = 1'b1;
    DIn    = b;
    Sel    = s;
    @(posedge Clk); #1;
    DValid = 1'b0;
    Sel    = 1'b0;
  endtask

  task automatic push(input logic [127:0] pt, input logic [127:0] ct, input logic m);
    exp_t e;
    e.pt = pt; e.ct = ct; e.mode = m;
    sb.push_back(e);
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    check("ack_ry_low", {127'd0, Ry}, 128'd0);
    check("ack_dready", {127'd0, DReady}, 128'd1);
    check("ack_pt_zero", PT | CT, 128'd0);
  endtask

  // Monitor: each newly presented block is compared against the scoreboard.
  always @(negedge Clk) begin
    if (Ry && !prev_ry) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got block PT=%h CT=%h expected none", PT, CT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pt", PT, e.pt);
        check("sb_ct", CT, e.ct);
        check("sb_mode", {127'd0, Mode}, {127'd0, e.mode});
      end
    end
    prev_ry <= Ry;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_cnt;
    Rst = 1'b0; DIn = 8'd0; DValid = 1'b0; Sel = 1'b0; Clear = 1'b0; Ack = 1'b0;
    repeat (2) @(posedge Clk); #1;
    check("rst_dready", {127'd0, DReady}, 128'd1);
    check("rst_ry", {126'd0, Ry, Err}, 128'd0);
    check("rst_data", PT | CT, 128'd0);
    check("rst_mode", {127'd0, Mode}, 128'd0);
    Rst = 1'b1;
    @(posedge Clk); #1;

    // Plaintext 00..0F back to back, Ry exactly one cycle after the last byte.
    push(mk_block(8'h00), 128'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == 14) check("ry_before_last", {127'd0, Ry}, 128'd0);
    end
    check("ry_latency", {127'd0, Ry}, 128'd1);
    check("pt_value", PT, 128'h000102030405060708090A0B0C0D0E0F);
    do_ack();

    // Ciphertext, Sel only honoured on the first byte.
    push(128'd0, {128{1'b1}}, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'hFF, (i == 0));
    check("ct_mode", {127'd0, Mode}, 128'd1);

    // Bytes offered while FULL are refused and the block is held.
    DValid = 1'b1; DIn = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("full_dready", {127'd0, DReady}, 128'd0);
      check("full_hold_ct", CT, {128{1'b1}});
    end
    DValid = 1'b0;
    do_ack();

    // Async reset mid-block clears everything without a clock edge.
    for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + 8'(i)), (i == 0));
    check("partial_ct", CT, {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 72'd0});
    #2 Rst = 1'b0;
    #1;
    check("async_rst_data", PT | CT, 128'd0);
    check("async_rst_ctl", {125'd0, Mode, Ry, Err}, 128'd0);
    check("async_rst_dready", {127'd0, DReady}, 128'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    push(mk_block(8'h20), 128'd0, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + 8'(i)), 1'b0);
    do_ack();

    // Clear with a byte offered: byte dropped, next byte starts a new block.
    for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + 8'(i)), 1'b0);
    Clear = 1'b1; DValid = 1'b1; DIn = 8'h39;
    @(posedge Clk); #1;
    Clear = 1'b0; DValid = 1'b0;
    check("clear_data", PT | CT, 128'd0);
    check("clear_dready", {127'd0, DReady}, 128'd1);
    push(128'd0, mk_block(8'h40), 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) Ack = 1'b1;   // Ack while loading must be ignored
      if (i == 8) Ack = 1'b0;
      send_byte(8'(8'h40 + 8'(i)), (i == 0));
    end
    // Clear together with Ack in FULL acts as Clear.
    Clear = 1'b1; Ack = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0; Ack = 1'b0;
    check("clear_ack_data", PT | CT, 128'd0);
    check("clear_ack_ry", {126'd0, Ry, Mode}, 128'd0);

    // Stall after four bytes.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + 8'(i)), 1'b0);
    err_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (Err) err_cnt++;
    end
`ifdef INPUT_LOADER_TIMEOUT_EN
    check("timeout_err_pulses", 128'(err_cnt), 128'd1);
    check("timeout_pt", PT, 128'd0);
    push(mk_block(8'h50), 128'd0, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + 8'(i)), 1'b0);
`else
    check("stall_no_err", 128'(err_cnt), 128'd0);
    check("stall_pending", PT, {8'h50, 8'h51, 8'h52, 8'h53, 96'd0});
    check("stall_dready", {127'd0, DReady}, 128'd1);
    push(mk_block(8'h50), 128'd0, 1'b0);
    for (int i = 4; i < 16; i++) send_byte(8'(8'h50 + 8'(i)), 1'b0);
`endif
    do_ack();

    repeat (3) @(posedge Clk); #1;
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
